// File: rtl/ct_l2cache_pkg.sv
// Shared definitions for the L2 data-bank controller.
//   State encoding for the bank sequencer, bank geometry constants and a
//   helper that widens a per-bank mask to a full data-width mask.
package ct_l2cache_pkg;

   localparam int L2C_IDX_W  = 13;
   localparam int L2C_BANKS  = 4;
   localparam int L2C_BANK_W = 128;
   localparam int L2C_DATA_W = L2C_BANKS * L2C_BANK_W;

   typedef logic [1:0] l2c_state_t;

   localparam l2c_state_t ST_IDLE  = 2'd0;
   localparam l2c_state_t ST_SETUP = 2'd1;
   localparam l2c_state_t ST_LAT   = 2'd2;
   localparam l2c_state_t ST_RESP  = 2'd3;

   function automatic logic [L2C_DATA_W-1:0] bank_mask_expand(input logic [L2C_BANKS-1:0] m);
      logic [L2C_DATA_W-1:0] r;
      for (int i = 0; i < L2C_BANKS; i++) begin
         r[i*L2C_BANK_W +: L2C_BANK_W] = {L2C_BANK_W{m[i]}};
      end
      return r;
   endfunction

endpackage

// File: rtl/ct_l2cache_rr_arb2.sv
// Two-requester round-robin arbiter (read vs. write).
//   clk, rst   : clock, synchronous active-high reset
//   en         : arbitration allowed this cycle (controller idle, not in reset)
//   req_rd/wr  : request valids
//   upd        : a grant was accepted; remember who got it
//   gnt_rd/wr  : combinational grants
// The last-grant pointer resets to "write" so a read wins the first tie.
module ct_l2cache_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_rd,
   input  logic req_wr,
   input  logic upd,
   output logic gnt_rd,
   output logic gnt_wr
);

   logic last_wr;

   always_ff @(posedge clk) begin
      if (rst)
         last_wr <= 1'b1;
      else if (upd)
         last_wr <= gnt_wr;
   end

   assign gnt_rd = en & req_rd & (~req_wr | last_wr);
   assign gnt_wr = en & req_wr & (~req_rd | ~last_wr);

endmodule

// File: rtl/ct_l2cache_data_bank_ctrl.sv
// Sequencer/arbiter for the four 128-bit L2 data RAM banks.
//   forever_cpuclk, cpurst          : clock, synchronous active-high reset
//   rd_req_* / rd_resp_*            : read request handshake, 512-bit response
//   wr_req_* / wr_done              : write request handshake, completion pulse
//   l2c_data_*                      : bank RAM interface (cen/wen active low)
// Parameters: SETUP_CYC (1..4) cycles of chip enable, LAT_CYC (1..8) wait
// cycles before read data is valid.
// Optional: CT_L2C_DATA_DOUT_FLOP_EN registers l2c_data_dout once before
// capture and stretches LAT by one cycle to match.
//
// state | meaning
// IDLE  | arbitrate; accept one request
// SETUP | chip enable asserted for the masked banks, SETUP_CYC cycles
// LAT   | enables released, waiting for RAM data; read captured on last cycle
// RESP  | one-cycle rd_resp_vld or wr_done
module ct_l2cache_data_bank_ctrl
   import ct_l2cache_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int LAT_CYC   = 2
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  rd_req_vld,
   output logic                  rd_req_rdy,
   input  logic [L2C_IDX_W-1:0]  rd_req_idx,
   input  logic [L2C_BANKS-1:0]  rd_req_mask,
   output logic                  rd_resp_vld,
   output logic [L2C_DATA_W-1:0] rd_resp_data,
   input  logic                  wr_req_vld,
   output logic                  wr_req_rdy,
   input  logic [L2C_IDX_W-1:0]  wr_req_idx,
   input  logic [L2C_BANKS-1:0]  wr_req_mask,
   input  logic [L2C_DATA_W-1:0] wr_req_data,
   output logic                  wr_done,
   output logic [L2C_BANKS-1:0]  l2c_data_ram_cen,
   output logic [L2C_BANKS-1:0]  l2c_data_wen,
   output logic [L2C_IDX_W-1:0]  l2c_data_index0,
   output logic [L2C_IDX_W-1:0]  l2c_data_index1,
   output logic [L2C_IDX_W-1:0]  l2c_data_index2,
   output logic [L2C_IDX_W-1:0]  l2c_data_index3,
   output logic [L2C_DATA_W-1:0] l2c_data_din,
   input  logic [L2C_DATA_W-1:0] l2c_data_dout
);

`ifdef CT_L2C_DATA_DOUT_FLOP_EN
   localparam int LAT_TOT = LAT_CYC + 1;
   localparam int CNT_W   = 4;
`else
   localparam int LAT_TOT = LAT_CYC;
   localparam int CNT_W   = 3;
`endif

   l2c_state_t            state;
   logic [CNT_W-1:0]      cnt;
   logic                  op_wr;
   logic [L2C_BANKS-1:0]  mask_q;
   logic [L2C_IDX_W-1:0]  idx_q;
   logic [L2C_DATA_W-1:0] din_q;
   logic [L2C_DATA_W-1:0] rd_data_q;
   logic [L2C_DATA_W-1:0] dout_src;
   logic                  arb_en;
   logic                  acc;

   assign arb_en = (state == ST_IDLE) & ~cpurst;
   assign acc    = rd_req_rdy | wr_req_rdy;

   ct_l2cache_rr_arb2 u_arb (
      .clk    (forever_cpuclk),
      .rst    (cpurst),
      .en     (arb_en),
      .req_rd (rd_req_vld),
      .req_wr (wr_req_vld),
      .upd    (acc),
      .gnt_rd (rd_req_rdy),
      .gnt_wr (wr_req_rdy)
   );

`ifdef CT_L2C_DATA_DOUT_FLOP_EN
   logic [L2C_DATA_W-1:0] dout_q;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst)
         dout_q <= '0;
      else
         dout_q <= l2c_data_dout;
   end

   assign dout_src = dout_q;
`else
   assign dout_src = l2c_data_dout;
`endif

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         op_wr     <= 1'b0;
         mask_q    <= '0;
         idx_q     <= '0;
         din_q     <= '0;
         rd_data_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (acc) begin
                  state  <= ST_SETUP;
                  cnt    <= CNT_W'(SETUP_CYC - 1);
                  op_wr  <= wr_req_rdy;
                  mask_q <= wr_req_rdy ? wr_req_mask : rd_req_mask;
                  idx_q  <= wr_req_rdy ? wr_req_idx : rd_req_idx;
                  // A read carries no data, so din keeps the last write's value.
                  if (wr_req_rdy)
                     din_q <= wr_req_data;
               end
            end
            ST_SETUP: begin
               if (cnt == '0) begin
                  state <= ST_LAT;
                  cnt   <= CNT_W'(LAT_TOT - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_LAT: begin
               if (cnt == '0) begin
                  state <= ST_RESP;
                  if (!op_wr)
                     rd_data_q <= dout_src & bank_mask_expand(mask_q);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign l2c_data_ram_cen = (state == ST_SETUP) ? ~mask_q : '1;
   assign l2c_data_wen     = (state == ST_SETUP) ? ~(mask_q & {L2C_BANKS{op_wr}}) : '1;
   assign l2c_data_index0  = idx_q;
   assign l2c_data_index1  = idx_q;
   assign l2c_data_index2  = idx_q;
   assign l2c_data_index3  = idx_q;
   assign l2c_data_din     = din_q;
   assign rd_resp_vld      = (state == ST_RESP) & ~op_wr;
   assign wr_done          = (state == ST_RESP) & op_wr;
   assign rd_resp_data     = rd_data_q;

endmodule

// File: tb/tb_ct_l2cache_data_bank_ctrl.sv
// Bench for ct_l2cache_data_bank_ctrl: one default-parameter instance and one
// with SETUP_CYC=3/LAT_CYC=4 share the stimulus; each scenario looks at one of
// them. Expected timing comes from the accept cycle plus S, L and the optional
// dout flop stage; expected read data is the bank data seen in cycle S+L.
`timescale 1ns/1ps
module tb_ct_l2cache_data_bank_ctrl;

   localparam int S0 = 1, L0 = 2, S1 = 3, L1 = 4;
`ifdef CT_L2C_DATA_DOUT_FLOP_EN
   localparam int EXT = 1;
`else
   localparam int EXT = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         rd_vld = 1'b0, wr_vld = 1'b0;
   logic [12:0]  rd_idx = '0, wr_idx = '0;
   logic [3:0]   rd_mask = '0, wr_mask = '0;
   logic [511:0] wr_data = '0, dout = '0;

   logic         rd_rdy[2], wr_rdy[2], rvld[2], wdone[2];
   logic [511:0] rdata[2], din[2];
   logic [3:0]   cen[2], wen[2];
   logic [12:0]  ix0[2], ix1[2], ix2[2], ix3[2];

   int checks = 0;
   int failures = 0;
   bit ptr_wr[2];

   ct_l2cache_data_bank_ctrl #(.SETUP_CYC(S0), .LAT_CYC(L0)) u_dut0 (
      .forever_cpuclk(clk), .cpurst(rst),
      .rd_req_vld(rd_vld), .rd_req_rdy(rd_rdy[0]), .rd_req_idx(rd_idx), .rd_req_mask(rd_mask),
      .rd_resp_vld(rvld[0]), .rd_resp_data(rdata[0]),
      .wr_req_vld(wr_vld), .wr_req_rdy(wr_rdy[0]), .wr_req_idx(wr_idx), .wr_req_mask(wr_mask),
      .wr_req_data(wr_data), .wr_done(wdone[0]),
      .l2c_data_ram_cen(cen[0]), .l2c_data_wen(wen[0]),
      .l2c_data_index0(ix0[0]), .l2c_data_index1(ix1[0]), .l2c_data_index2(ix2[0]), .l2c_data_index3(ix3[0]),
      .l2c_data_din(din[0]), .l2c_data_dout(dout));

   ct_l2cache_data_bank_ctrl #(.SETUP_CYC(S1), .LAT_CYC(L1)) u_dut1 (
      .forever_cpuclk(clk), .cpurst(rst),
      .rd_req_vld(rd_vld), .rd_req_rdy(rd_rdy[1]), .rd_req_idx(rd_idx), .rd_req_mask(rd_mask),
      .rd_resp_vld(rvld[1]), .rd_resp_data(rdata[1]),
      .wr_req_vld(wr_vld), .wr_req_rdy(wr_rdy[1]), .wr_req_idx(wr_idx), .wr_req_mask(wr_mask),
      .wr_req_data(wr_data), .wr_done(wdone[1]),
      .l2c_data_ram_cen(cen[1]), .l2c_data_wen(wen[1]),
      .l2c_data_index0(ix0[1]), .l2c_data_index1(ix1[1]), .l2c_data_index2(ix2[1]), .l2c_data_index3(ix3[1]),
      .l2c_data_din(din[1]), .l2c_data_dout(dout));

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] keep_banks(input logic [511:0] v, input logic [3:0] m);
      logic [511:0] r = '0;
      for (int i = 0; i < 4; i++) if (m[i]) r[i*128 +: 128] = v[i*128 +: 128];
      return r;
   endfunction

   // Advance to just after the next rising edge and present new bank data.
   task automatic tick();
      @(posedge clk);
      #1;
      dout = rnd512();
   endtask

   task automatic do_reset();
      rst = 1'b1; rd_vld = 1'b0; wr_vld = 1'b0;
      tick(); tick();
      rst = 1'b0;
      ptr_wr[0] = 1'b1; ptr_wr[1] = 1'b1;
   endtask

   // Entered at the start of cycle 0 with request fields already driven.
   task automatic do_txn(input int sel, input bit rv, input bit wv, input bit hold);
      int s, l, last;
      bit win_wr;
      logic [3:0] m, ecen, ewen;
      logic [12:0] ix;
      logic [511:0] d, samp, exp_data;
      s = sel ? S1 : S0;
      l = sel ? L1 : L0;
      last = s + l + 1 + EXT;
      rd_vld = rv; wr_vld = wv;
      #1;
      win_wr = wv && (!rv || !ptr_wr[sel]);
      checks++;
      if (rd_rdy[sel] !== (rv && !win_wr)) begin
         failures++; $display("FAIL rd_rdy_accept sel=%0d got=%b exp=%b", sel, rd_rdy[sel], rv && !win_wr);
      end
      checks++;
      if (wr_rdy[sel] !== win_wr) begin
         failures++; $display("FAIL wr_rdy_accept sel=%0d got=%b exp=%b", sel, wr_rdy[sel], win_wr);
      end
      if (!rv && !wv) return;
      ptr_wr[sel] = win_wr;
      m  = win_wr ? wr_mask : rd_mask;
      ix = win_wr ? wr_idx : rd_idx;
      d  = wr_data;
      samp = '0;
      exp_data = '0;
      for (int k = 1; k <= last; k++) begin
         tick();
         if (!hold) begin rd_vld = 1'b0; wr_vld = 1'b0; end
         #1;
         if (k == s + l) samp = dout;
         ecen = (k <= s) ? ~m : 4'hF;
         ewen = (k <= s) ? ~(m & {4{win_wr}}) : 4'hF;
         checks++;
         if (cen[sel] !== ecen) begin
            failures++; $display("FAIL cen sel=%0d k=%0d got=%b exp=%b", sel, k, cen[sel], ecen);
         end
         checks++;
         if (wen[sel] !== ewen) begin
            failures++; $display("FAIL wen sel=%0d k=%0d got=%b exp=%b", sel, k, wen[sel], ewen);
         end
         checks++;
         if ({ix0[sel], ix1[sel], ix2[sel], ix3[sel]} !== {4{ix}}) begin
            failures++; $display("FAIL index sel=%0d k=%0d got=%h exp=%h", sel, k, ix0[sel], ix);
         end
         if (win_wr) begin
            checks++;
            if (din[sel] !== d) begin
               failures++; $display("FAIL din sel=%0d k=%0d got=%h exp=%h", sel, k, din[sel], d);
            end
         end
         checks++;
         if ({rd_rdy[sel], wr_rdy[sel]} !== 2'b00) begin
            failures++; $display("FAIL rdy_busy sel=%0d k=%0d got=%b exp=00", sel, k, {rd_rdy[sel], wr_rdy[sel]});
         end
         checks++;
         if (rvld[sel] !== (k == last && !win_wr)) begin
            failures++; $display("FAIL rd_resp_vld sel=%0d k=%0d got=%b exp=%b", sel, k, rvld[sel], k == last && !win_wr);
         end
         checks++;
         if (wdone[sel] !== (k == last && win_wr)) begin
            failures++; $display("FAIL wr_done sel=%0d k=%0d got=%b exp=%b", sel, k, wdone[sel], k == last && win_wr);
         end
         if (k == last && !win_wr) begin
            exp_data = keep_banks(samp, m);
            checks++;
            if (rdata[sel] !== exp_data) begin
               failures++; $display("FAIL rd_resp_data sel=%0d got=%h exp=%h", sel, rdata[sel], exp_data);
            end
         end
      end
      tick();
      #1;
      checks++;
      if ({rvld[sel], wdone[sel]} !== 2'b00) begin
         failures++; $display("FAIL resp_one_cycle sel=%0d got=%b exp=00", sel, {rvld[sel], wdone[sel]});
      end
      if (!win_wr) begin
         checks++;
         if (rdata[sel] !== exp_data) begin
            failures++; $display("FAIL rd_data_hold sel=%0d got=%h exp=%h", sel, rdata[sel], exp_data);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rd_vld = 1'b1; wr_vld = 1'b1;
      rd_idx = 13'h0F0; rd_mask = 4'hF; wr_idx = 13'h111; wr_mask = 4'hF; wr_data = rnd512();
      for (int c = 0; c < 3; c++) begin
         tick();
         #1;
         for (int sel = 0; sel < 2; sel++) begin
            checks++;
            if ({rd_rdy[sel], wr_rdy[sel]} !== 2'b00) begin
               failures++; $display("FAIL reset_rdy sel=%0d got=%b exp=00", sel, {rd_rdy[sel], wr_rdy[sel]});
            end
            checks++;
            if ({cen[sel], wen[sel]} !== 8'hFF) begin
               failures++; $display("FAIL reset_cen_wen sel=%0d got=%h exp=ff", sel, {cen[sel], wen[sel]});
            end
            checks++;
            if ({ix0[sel], ix3[sel], rvld[sel], wdone[sel]} !== '0) begin
               failures++; $display("FAIL reset_idx_resp sel=%0d got=%h exp=0", sel, {ix0[sel], ix3[sel], rvld[sel], wdone[sel]});
            end
            checks++;
            if ({din[sel], rdata[sel]} !== '0) begin
               failures++; $display("FAIL reset_data sel=%0d got=%h exp=0", sel, din[sel] | rdata[sel]);
            end
         end
      end
      rd_vld = 1'b0; wr_vld = 1'b0;
      rst = 1'b0;
      ptr_wr[0] = 1'b1; ptr_wr[1] = 1'b1;
   endtask

   task automatic test_single_read();
      rd_idx = 13'h1A5; rd_mask = 4'hF;
      do_txn(0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_write();
      wr_idx = 13'h0C3; wr_mask = 4'b0101;
      for (int i = 0; i < 4; i++) wr_data[i*128 +: 128] = {32{4'(i)}};
      do_txn(0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_reset();
      rd_idx = 13'h0AA; rd_mask = 4'b1100;
      wr_idx = 13'h155; wr_mask = 4'b0011; wr_data = rnd512();
      for (int n = 0; n < 4; n++) do_txn(0, 1'b1, 1'b1, 1'b1);
      rd_vld = 1'b0; wr_vld = 1'b0;
   endtask

   task automatic test_params();
      do_reset();
      rd_idx = 13'h0777; rd_mask = 4'b0010;
      do_txn(1, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 6; n++) begin
         rd_idx = 13'($urandom); rd_mask = 4'($urandom);
         wr_idx = 13'($urandom); wr_mask = 4'($urandom); wr_data = rnd512();
         do_txn(1, $urandom_range(0, 1) == 1, 1'b1, 1'b0);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      rd_idx = 13'h0321; rd_mask = 4'hF;
      rd_vld = 1'b1;
      #1;
      checks++;
      if (rd_rdy[0] !== 1'b1) begin
         failures++; $display("FAIL midrst_accept got=%b exp=1", rd_rdy[0]);
      end
      tick();
      rd_vld = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rd_vld = 1'b1;
      #1;
      checks++;
      if ({cen[0], wen[0]} !== 8'hFF) begin
         failures++; $display("FAIL midrst_cen got=%h exp=ff", {cen[0], wen[0]});
      end
      checks++;
      if ({rvld[0], rd_rdy[0], ix0[0]} !== '0) begin
         failures++; $display("FAIL midrst_resp_rdy_idx got=%h exp=0", {rvld[0], rd_rdy[0], ix0[0]});
      end
      checks++;
      if (rdata[0] !== '0) begin
         failures++; $display("FAIL midrst_rdata got=%h exp=0", rdata[0]);
      end
      tick();
      rst = 1'b0;
      ptr_wr[0] = 1'b1; ptr_wr[1] = 1'b1;
      #1;
      checks++;
      if (rvld[0] !== 1'b0) begin
         failures++; $display("FAIL midrst_no_resp got=%b exp=0", rvld[0]);
      end
      rd_idx = 13'h1111; rd_mask = 4'b1001;
      do_txn(0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 40; n++) begin
         bit rv, wv;
         rv = $urandom_range(0, 1) == 1;
         wv = $urandom_range(0, 1) == 1;
         rd_idx = 13'($urandom); rd_mask = 4'($urandom);
         wr_idx = 13'($urandom); wr_mask = 4'($urandom); wr_data = rnd512();
         do_txn(0, rv, wv, $urandom_range(0, 1) == 1);
         if (!rv && !wv) tick();
      end
      rd_vld = 1'b0; wr_vld = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_back_to_back();
      test_params();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
